sequential_divider: RTL

Multi-cycle unsigned integer divider for the datapath, the inverse operation of the existing combinational array multiplier. It computes quotient and remainder of two `width`-bit operands using a restoring shift-subtract algorithm, one quotient bit per clock. Operands and results are exchanged over a start/done handshake. Results are held in registers until the next accepted operation, so the control unit can sample them at any later cycle.

---
 rtl/sequential_divider.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset, aborts any operation
//   start_i        request a division, accepted in idle or in the done cycle
//   dividend_i     numerator, sampled on an accepted start
//   divisor_i      denominator, sampled on an accepted start
//   busy_o         high while iterations are in progress
//   done_o         one-cycle pulse, results valid
//   quotient_o     registered quotient, held until the next completion
//   remainder_o    registered remainder, held until the next completion
//   div_by_zero_o  last completed operation had a zero divisor
module sequential_divider #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [Width-1:0] dividend_i,
  input  logic [Width-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] quotient_o,
  output logic [Width-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] dvd_q, dvd_d;       // dividend shifts out, quotient bits shift in
  logic [Width-1:0] dvs_q, dvs_d;
  logic [Width:0]   prem_q, prem_d;     // partial remainder
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [Width:0]   shifted;
  logic [Width:0]   trial;

  // The partial remainder stays below the divisor, so its top bit is always zero
  // before the shift and only the low bits feed the shifted value.
  logic unused_prem_msb;
  assign unused_prem_msb = prem_q[Width];

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    accept  = start_i && ((state_q == StIdle) || (state_q == StDone));
    shifted = {prem_q[Width-1:0], dvd_q[Width-1]};
    trial   = shifted - {1'b0, dvs_q};

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          dvd_d  = dividend_i;
          dvs_d  = divisor_i;
          prem_d = '0;
          cnt_d  = '0;
          if (divisor_i == '0) begin
            // Zero divisor completes immediately without iterating.
            state_d = StDone;
            quo_d   = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (trial[Width]) begin
          // Negative trial: keep the shifted remainder, quotient bit 0.
          prem_d = shifted;
          dvd_d  = {dvd_q[Width-2:0], 1'b0};
        end else begin
          prem_d = trial;
          dvd_d  = {dvd_q[Width-2:0], 1'b1};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          quo_d   = dvd_d;
          rem_d   = prem_d[Width-1:0];
          dbz_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o        = (state_q == StRun);
  assign done_o        = (state_q == StDone);
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
